// File: rtl/srcnn_mul_pkg.sv
// Shared constants for the SRCNN pipelined multiplier: operand mode encodings
// and the supported pipeline depth range.
package srcnn_mul_pkg;

   localparam logic MUL_UNSIGNED = 1'b0;
   localparam logic MUL_SIGNED   = 1'b1;

   localparam int NUM_STAGE_MIN = 1;
   localparam int NUM_STAGE_MAX = 8;

   // Keeps an out-of-range depth parameter inside the supported window.
   function automatic int clamp_stages(input int n);
      if (n < NUM_STAGE_MIN) return NUM_STAGE_MIN;
      if (n > NUM_STAGE_MAX) return NUM_STAGE_MAX;
      return n;
   endfunction

endpackage

// File: rtl/srcnn_mul_stage.sv
// One pipeline slot: a payload register plus its valid bit, advancing on
// i_en and cleared by the synchronous reset.
module srcnn_mul_stage
   import srcnn_mul_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_en,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data
);

   logic             r_valid;
   logic [WIDTH-1:0] r_data;

   // NOTE: the payload is cleared along with the valid bit so the final stage
   // presents dout = 0 and ovf = 0 straight out of reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_en) begin
         // NOTE: non-blocking updates let every slot sample its upstream
         // neighbour's old value, so the chain shifts by exactly one slot.
         r_valid <= i_valid;
         r_data  <= i_data;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/srcnn_mul_pipe.sv
// Pipelined unsigned/signed multiplier with valid/ready flow control, a
// registered product in the first stage and overflow handling in the last.
module srcnn_mul_pipe
   import srcnn_mul_pkg::*;
#(
   parameter int ID         = 1,
   parameter int NUM_STAGE  = 3,
   parameter int din0_WIDTH = 3,
   parameter int din1_WIDTH = 10,
   parameter int dout_WIDTH = 12,
   parameter int SAT        = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  mode,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [dout_WIDTH-1:0] dout,
   output logic                  ovf
);

   localparam int STAGES = clamp_stages(NUM_STAGE);
   localparam int PW     = din0_WIDTH + din1_WIDTH + 2;
   localparam int MW     = PW + 1;
   localparam int OW     = dout_WIDTH + 1;

   logic w_en;

   // One shared enable: a full output slot with no taker freezes every stage.
   assign w_en     = !out_valid || out_ready;
   assign in_ready = w_en;

   logic                  w_signed;
   logic [din0_WIDTH:0]   w_a_ext;
   logic [din1_WIDTH:0]   w_b_ext;
   logic signed [PW-1:0]  w_a_full;
   logic signed [PW-1:0]  w_b_full;
   logic signed [PW-1:0]  w_prod;

   assign w_signed = (mode == MUL_SIGNED);
   assign w_a_ext  = {w_signed & din0[din0_WIDTH-1], din0};
   assign w_b_ext  = {w_signed & din1[din1_WIDTH-1], din1};
   assign w_a_full = {{(PW-din0_WIDTH-1){w_a_ext[din0_WIDTH]}}, w_a_ext};
   assign w_b_full = {{(PW-din1_WIDTH-1){w_b_ext[din1_WIDTH]}}, w_b_ext};
   assign w_prod   = w_a_full * w_b_full;

   // Chain node 0 is the combinational product; node k is the output of slot k.
   logic [MW-1:0] w_chain_data  [STAGES];
   logic          w_chain_valid [STAGES];

   assign w_chain_data[0]  = {mode, w_prod};
   assign w_chain_valid[0] = in_valid;

   for (genvar i = 0; i < STAGES - 1; i++) begin : g_mid
      srcnn_mul_stage #(.WIDTH(MW)) u_stage (
         .clk     (clk),
         .reset   (reset),
         .i_en    (w_en),
         .i_valid (w_chain_valid[i]),
         .i_data  (w_chain_data[i]),
         .o_valid (w_chain_valid[i+1]),
         .o_data  (w_chain_data[i+1])
      );
   end

   logic [PW-1:0]         w_res_prod;
   logic                  w_res_mode;
   logic                  w_neg;
   logic                  w_hi_unsigned;
   logic                  w_top_all1;
   logic                  w_top_all0;
   logic                  w_ovf;
   logic [dout_WIDTH-1:0] w_sat_val;
   logic [dout_WIDTH-1:0] w_dout;

   assign {w_res_mode, w_res_prod} = w_chain_data[STAGES-1];

   // Unsigned fits when no bit above dout_WIDTH is set; signed fits when the
   // bits from the result sign upward are all copies of one value.
   assign w_neg         = w_res_prod[PW-1];
   assign w_hi_unsigned = |w_res_prod[PW-2:dout_WIDTH];
   assign w_top_all1    = &w_res_prod[PW-1:dout_WIDTH-1];
   assign w_top_all0    = ~|w_res_prod[PW-1:dout_WIDTH-1];

   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      w_ovf     = 1'b0;
      w_sat_val = '0;
      if (w_res_mode == MUL_SIGNED) begin
         w_ovf     = !(w_top_all1 || w_top_all0);
         w_sat_val = w_neg ? {1'b1, {(dout_WIDTH-1){1'b0}}}
                           : {1'b0, {(dout_WIDTH-1){1'b1}}};
      end else begin
         w_ovf     = w_neg || w_hi_unsigned;
         w_sat_val = w_neg ? '0 : '1;
      end
      w_dout = (SAT != 0 && w_ovf) ? w_sat_val : w_res_prod[dout_WIDTH-1:0];
   end

   logic [OW-1:0] w_out_data;

   srcnn_mul_stage #(.WIDTH(OW)) u_last (
      .clk     (clk),
      .reset   (reset),
      .i_en    (w_en),
      .i_valid (w_chain_valid[STAGES-1]),
      .i_data  ({w_ovf, w_dout}),
      .o_valid (out_valid),
      .o_data  (w_out_data)
   );

   assign {ovf, dout} = w_out_data;

endmodule
